line_sensor_steer: RTL and testbench

Next-generation line-follower front end. It synchronises and debounces a parametrised number of reflective line sensors, with a separate debounce counter per channel. A registered steering state machine uses the front sensor pair to drive the 4-bit motor-direction code. Compared with the fixed four-sensor direction decoder, it adds per-channel debounce, an enable/idle mode, oversteer recovery (SEARCH), a halt-on-marker latch and a direction-change strobe.

---
 rtl/line_sensor_steer.sv | 172 +++++++++++++++++
 tb/tb_line_sensor_steer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_steer.sv
// Line-follower front end: per-channel synchroniser and debounce, then a registered
// steering FSM on the front sensor pair with search recovery, halt latch and change strobe.
module line_sensor_steer #(
    parameter int unsigned NUM_SENS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 12_500_000,
    parameter int unsigned LOST_TIMEOUT    = 50_000_000,
    parameter int unsigned SENS_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SENS-1:0] sens_in,
    input  logic                enable,
    output logic [NUM_SENS-1:0] sens_stable,
    output logic [3:0]          dir,
    output logic [1:0]          state,
    output logic                dir_chg
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TmrW = $clog2(LOST_TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(LOST_TIMEOUT - 1);
    localparam logic [NUM_SENS-1:0] InactLvl =
        (SENS_ACTIVE_LOW != 0) ? {NUM_SENS{1'b1}} : {NUM_SENS{1'b0}};

    localparam logic [3:0] DirFwd   = 4'b0000;
    localparam logic [3:0] DirVeerL = 4'b0101;
    localparam logic [3:0] DirVeerR = 4'b1001;
    localparam logic [3:0] DirSpinL = 4'b0110;
    localparam logic [3:0] DirSpinR = 4'b1010;
    localparam logic [3:0] DirStop  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StFollow = 2'b01,
        StSearch = 2'b10,
        StHalt   = 2'b11
    } state_e;

    logic [NUM_SENS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_SENS-1:0] stable_q, stable_d, act;
    logic [CntW-1:0]     cnt_q [NUM_SENS];
    logic [CntW-1:0]     cnt_d [NUM_SENS];

    state_e          state_q, state_d;
    logic [3:0]      dir_q, dir_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            side_q, side_d;   // 1 = last veer was to the left
    logic [1:0]      f_prev_q, f_prev_d;
    logic            dir_chg_q, dir_chg_d;
    logic [1:0]      f;

    always_comb begin
        sync1_d  = sens_in;
        sync2_d  = sync1_q;
        act      = (SENS_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        stable_d = stable_q;
        for (int i = 0; i < NUM_SENS; i++) begin
            cnt_d[i] = '0;
            if (act[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = act[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        f         = stable_q[1:0];
        state_d   = state_q;
        dir_d     = dir_q;
        tmr_d     = tmr_q;
        side_d    = side_q;
        f_prev_d  = f;
        if (!enable) begin
            state_d = StIdle;
            dir_d   = DirStop;
            tmr_d   = '0;
        end else if (f == 2'b11 && (state_q == StFollow || state_q == StSearch)) begin
            state_d = StHalt;
            dir_d   = DirStop;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFollow;
                    dir_d   = DirFwd;
                    tmr_d   = '0;
                end
                StFollow: begin
                    if (f == 2'b00) begin
                        dir_d = DirFwd;
                        tmr_d = '0;
                    end else if (f != f_prev_q) begin
                        dir_d  = (f == 2'b01) ? DirVeerL : DirVeerR;
                        side_d = (f == 2'b01);
                        tmr_d  = '0;
                    end else if (tmr_q == TmrMax) begin
                        state_d = StSearch;
                        dir_d   = side_q ? DirSpinL : DirSpinR;
                        tmr_d   = '0;
                    end else begin
                        dir_d  = (f == 2'b01) ? DirVeerL : DirVeerR;
                        side_d = (f == 2'b01);
                        tmr_d  = tmr_q + TmrW'(1);
                    end
                end
                StSearch: begin
                    if (f == 2'b00) begin
                        state_d = StFollow;
                        dir_d   = DirFwd;
                        tmr_d   = '0;
                    end else if (tmr_q == TmrMax) begin
                        state_d = StHalt;
                        dir_d   = DirStop;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                StHalt: begin
                    dir_d = DirStop;
                    tmr_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    dir_d   = DirStop;
                    tmr_d   = '0;
                end
            endcase
        end
        dir_chg_d = (dir_d != dir_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= InactLvl;
            sync2_q   <= InactLvl;
            stable_q  <= '0;
            for (int i = 0; i < NUM_SENS; i++) begin
                cnt_q[i] <= '0;
            end
            state_q   <= StIdle;
            dir_q     <= DirStop;
            tmr_q     <= '0;
            side_q    <= 1'b0;
            f_prev_q  <= 2'b00;
            dir_chg_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            for (int i = 0; i < NUM_SENS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q   <= state_d;
            dir_q     <= dir_d;
            tmr_q     <= tmr_d;
            side_q    <= side_d;
            f_prev_q  <= f_prev_d;
            dir_chg_q <= dir_chg_d;
        end
    end

    assign sens_stable = stable_q;
    assign dir         = dir_q;
    assign state       = state_q;
    assign dir_chg     = dir_chg_q;

endmodule

// File: tb/tb_line_sensor_steer.sv
// Directed bench for line_sensor_steer: per-cycle vector table for debounce and follow,
// hand-written sequences for search, timeout, marker, priority and async reset.
module tb_line_sensor_steer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sens_in;
    logic       enable;
    logic [3:0] sens_stable;
    logic [3:0] dir;
    logic [1:0] state;
    logic       dir_chg;

    int n_vec = 0;
    int n_err = 0;

    line_sensor_steer #(
        .NUM_SENS        (4),
        .DEBOUNCE_CYCLES (4),
        .LOST_TIMEOUT    (16),
        .SENS_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sens_in     (sens_in),
        .enable      (enable),
        .sens_stable (sens_stable),
        .dir         (dir),
        .state       (state),
        .dir_chg     (dir_chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] sens;
        logic [3:0] st;
        logic [1:0] state;
        logic [3:0] dir;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic en, input logic [3:0] sens,
                       input logic [3:0] st, input logic [1:0] s, input logic [3:0] d,
                       input logic c);
        vec_t v;
        v.en = en; v.sens = sens; v.st = st; v.state = s; v.dir = d; v.chg = c;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [3:0] st, input logic [1:0] s,
                         input logic [3:0] d, input logic c);
        n_vec++;
        if ({sens_stable, state, dir, dir_chg} !== {st, s, d, c}) begin
            n_err++;
            $display("FAIL %s: got stable=%b state=%b dir=%b chg=%b, want stable=%b state=%b dir=%b chg=%b",
                     nm, sens_stable, state, dir, dir_chg, st, s, d, c);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From FOLLOW with no line seen: hold LF until the veer times out into SEARCH.
    task automatic run_to_search(input string nm);
        sens_in = 4'b1101;
        tick(6);  check({nm, " lf stable"}, 4'b0010, 2'b01, 4'b0000, 1'b0);
        tick(1);  check({nm, " veer_r"},    4'b0010, 2'b01, 4'b1001, 1'b1);
        tick(15); check({nm, " veer hold"}, 4'b0010, 2'b01, 4'b1001, 1'b0);
        tick(1);  check({nm, " search"},    4'b0010, 2'b10, 4'b1010, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Debounce: short pulse rejected, held level accepted on edge 6.
        add(3, 1'b0, 4'b1110, 4'b0000, 2'b00, 4'b1111, 1'b0);
        add(4, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b1111, 1'b0);
        add(5, 1'b0, 4'b1110, 4'b0000, 2'b00, 4'b1111, 1'b0);
        add(1, 1'b0, 4'b1110, 4'b0001, 2'b00, 4'b1111, 1'b0);
        add(5, 1'b0, 4'b1111, 4'b0001, 2'b00, 4'b1111, 1'b0);
        add(1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b1111, 1'b0);
        // Non-front channel only
        add(5, 1'b0, 4'b0111, 4'b0000, 2'b00, 4'b1111, 1'b0);
        add(1, 1'b0, 4'b0111, 4'b1000, 2'b00, 4'b1111, 1'b0);
        add(5, 1'b0, 4'b1111, 4'b1000, 2'b00, 4'b1111, 1'b0);
        add(1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b1111, 1'b0);
        // Follow: enable, RF veer left, release back to forward
        add(1, 1'b1, 4'b1111, 4'b0000, 2'b01, 4'b0000, 1'b1);
        add(1, 1'b1, 4'b1111, 4'b0000, 2'b01, 4'b0000, 1'b0);
        add(5, 1'b1, 4'b1110, 4'b0000, 2'b01, 4'b0000, 1'b0);
        add(1, 1'b1, 4'b1110, 4'b0001, 2'b01, 4'b0000, 1'b0);
        add(1, 1'b1, 4'b1110, 4'b0001, 2'b01, 4'b0101, 1'b1);
        add(1, 1'b1, 4'b1110, 4'b0001, 2'b01, 4'b0101, 1'b0);
        add(5, 1'b1, 4'b1111, 4'b0001, 2'b01, 4'b0101, 1'b0);
        add(1, 1'b1, 4'b1111, 4'b0000, 2'b01, 4'b0101, 1'b0);
        add(1, 1'b1, 4'b1111, 4'b0000, 2'b01, 4'b0000, 1'b1);
        add(1, 1'b1, 4'b1111, 4'b0000, 2'b01, 4'b0000, 1'b0);

        rst = 1'b1; enable = 1'b0; sens_in = 4'b1111;
        #1 check("reset", 4'b0000, 2'b00, 4'b1111, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            enable  = vecs[i].en;
            sens_in = vecs[i].sens;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].state, vecs[i].dir, vecs[i].chg);
        end

        // Oversteer recovery
        run_to_search("recover");
        sens_in = 4'b1111;
        tick(6); check("recover spin held", 4'b0000, 2'b10, 4'b1010, 1'b0);
        tick(1); check("recover follow",    4'b0000, 2'b01, 4'b0000, 1'b1);
        tick(2); check("recover settle",    4'b0000, 2'b01, 4'b0000, 1'b0);

        // Search timeout into HALT, sticky, exit via enable
        run_to_search("timeout");
        tick(15); check("timeout spin",   4'b0010, 2'b10, 4'b1010, 1'b0);
        tick(1);  check("timeout halt",   4'b0010, 2'b11, 4'b1111, 1'b1);
        sens_in = 4'b1111;
        tick(10); check("halt sticky",    4'b0000, 2'b11, 4'b1111, 1'b0);
        enable = 1'b0;
        tick(1);  check("halt to idle",   4'b0000, 2'b00, 4'b1111, 1'b0);
        enable = 1'b1;
        tick(1);  check("idle to follow", 4'b0000, 2'b01, 4'b0000, 1'b1);

        // Cross marker
        sens_in = 4'b1100;
        tick(6); check("marker stable", 4'b0011, 2'b01, 4'b0000, 1'b0);
        tick(1); check("marker halt",   4'b0011, 2'b11, 4'b1111, 1'b1);
        sens_in = 4'b1111; enable = 1'b0;
        tick(8); check("marker idle",   4'b0000, 2'b00, 4'b1111, 1'b0);
        enable = 1'b1;
        tick(1); check("marker rerun",  4'b0000, 2'b01, 4'b0000, 1'b1);
        tick(1); check("marker settle", 4'b0000, 2'b01, 4'b0000, 1'b0);

        // Enable drop on the search-timeout edge: IDLE wins
        run_to_search("prio");
        tick(15); check("prio spin", 4'b0010, 2'b10, 4'b1010, 1'b0);
        enable = 1'b0;
        tick(1);  check("prio idle", 4'b0010, 2'b00, 4'b1111, 1'b1);
        sens_in = 4'b1111;
        tick(8);  check("prio idle settle", 4'b0000, 2'b00, 4'b1111, 1'b0);
        enable = 1'b1;
        tick(1);  check("prio follow", 4'b0000, 2'b01, 4'b0000, 1'b1);
        tick(1);  check("prio settle", 4'b0000, 2'b01, 4'b0000, 1'b0);

        // Async reset mid-debounce, then full debounce after release
        sens_in = 4'b1110;
        tick(4); check("pre reset", 4'b0000, 2'b01, 4'b0000, 1'b0);
        #2 rst = 1'b1;
        #1 check("reset mid debounce", 4'b0000, 2'b00, 4'b1111, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(1); check("post reset follow", 4'b0000, 2'b01, 4'b0000, 1'b1);
        tick(4); check("post reset edge5",  4'b0000, 2'b01, 4'b0000, 1'b0);
        tick(1); check("post reset edge6",  4'b0001, 2'b01, 4'b0000, 1'b0);
        tick(1); check("post reset veer",   4'b0001, 2'b01, 4'b0101, 1'b1);
        sens_in = 4'b1111;
        tick(8); check("post reset fwd",    4'b0000, 2'b01, 4'b0000, 1'b0);

        // Async reset during SEARCH while dir_chg is high
        run_to_search("rst search");
        #2 rst = 1'b1;
        #1 check("reset in search", 4'b0000, 2'b00, 4'b1111, 1'b0);
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; sens_in = 4'b1111;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
